data_write_bus: RTL and testbench

DATA_WRITE_BUS -- requirements
Module: data_write_bus

---
 rtl/data_write_bus.sv | 172 +++++++++++++++++
 tb/tb_data_write_bus.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_write_bus.sv
// CPU write path to onboard RAM and the USB ACIA, stalling the CPU while a write completes.
// Optional feature macro: ROM_WRITE_TRAP_EN adds the sticky romWriteFault output.
module data_write_bus #(
    parameter int RAM_WE_CYCLES = 2,
    parameter int USB_TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] cpuData,
    input  logic       cpuRw,
    input  logic       cpuStart,
    input  logic       romSelect,
    input  logic       ramSelect,
    input  logic       usbSelect,
    output logic [7:0] ramDataOut,
    output logic       ramDataOe,
    output logic       ramWeN,
    output logic [7:0] usbDataOut,
    output logic       usbWrite,
    input  logic       usbReady,
    output logic       cpuHold,
    output logic       usbDropped
`ifdef ROM_WRITE_TRAP_EN
    ,
    output logic       romWriteFault
`endif
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RAM_SETUP  = 3'd1,
        RAM_WE     = 3'd2,
        RAM_HOLD   = 3'd3,
        USB_WAIT   = 3'd4,
        USB_STROBE = 3'd5
    } state_t;

    localparam logic [3:0] WE_LAST  = 4'(RAM_WE_CYCLES - 1);
    localparam logic [7:0] TMO_LAST = 8'(USB_TIMEOUT - 1);
    localparam logic       TMO_EN   = (USB_TIMEOUT != 0);

    state_t     state_q, state_d;
    logic [3:0] we_cnt_q, we_cnt_d;
    logic [7:0] usb_cnt_q, usb_cnt_d;
    logic [7:0] ram_data_q, ram_data_d;
    logic [7:0] usb_data_q, usb_data_d;
    logic       ram_oe_q, ram_oe_d;
    logic       ram_we_n_q, ram_we_n_d;
    logic       usb_write_q, usb_write_d;
    logic       cpu_hold_q, cpu_hold_d;
    logic       usb_dropped_q, usb_dropped_d;
`ifdef ROM_WRITE_TRAP_EN
    logic       rom_fault_q, rom_fault_d;
`endif

    // Next-state, data capture and counters; outputs are decoded from the next state
    // so the registered outputs line up with the state they describe.
    always_comb begin
        state_d       = state_q;
        we_cnt_d      = we_cnt_q;
        usb_cnt_d     = usb_cnt_q;
        ram_data_d    = ram_data_q;
        usb_data_d    = usb_data_q;
        usb_dropped_d = usb_dropped_q;
`ifdef ROM_WRITE_TRAP_EN
        rom_fault_d   = rom_fault_q;
`endif
        case (state_q)
            IDLE: begin
                if (cpuStart && !cpuRw) begin
                    if (romSelect) begin
`ifdef ROM_WRITE_TRAP_EN
                        rom_fault_d = 1'b1;
`endif
                        state_d = IDLE;
                    end else if (ramSelect) begin
                        ram_data_d = cpuData;
                        state_d    = RAM_SETUP;
                    end else if (usbSelect) begin
                        usb_data_d = cpuData;
                        usb_cnt_d  = 8'd0;
                        state_d    = USB_WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RAM_SETUP: begin
                we_cnt_d = 4'd0;
                state_d  = RAM_WE;
            end
            RAM_WE: begin
                if (we_cnt_q == WE_LAST) begin
                    state_d = RAM_HOLD;
                end else begin
                    we_cnt_d = we_cnt_q + 4'd1;
                end
            end
            RAM_HOLD: begin
                state_d = IDLE;
            end
            USB_WAIT: begin
                if (usbReady) begin
                    state_d = USB_STROBE;
                end else if (TMO_EN && (usb_cnt_q == TMO_LAST)) begin
                    state_d       = IDLE;
                    usb_dropped_d = 1'b1;
                end else begin
                    usb_cnt_d = usb_cnt_q + 8'd1;
                end
            end
            USB_STROBE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ram_oe_d    = (state_d == RAM_SETUP) || (state_d == RAM_WE) || (state_d == RAM_HOLD);
        ram_we_n_d  = (state_d != RAM_WE);
        usb_write_d = (state_d == USB_STROBE);
        cpu_hold_d  = (state_d != IDLE);
    end

    // State, counter, data and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            we_cnt_q      <= 4'd0;
            usb_cnt_q     <= 8'd0;
            ram_data_q    <= 8'h00;
            usb_data_q    <= 8'h00;
            ram_oe_q      <= 1'b0;
            ram_we_n_q    <= 1'b1;
            usb_write_q   <= 1'b0;
            cpu_hold_q    <= 1'b0;
            usb_dropped_q <= 1'b0;
`ifdef ROM_WRITE_TRAP_EN
            rom_fault_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            we_cnt_q      <= we_cnt_d;
            usb_cnt_q     <= usb_cnt_d;
            ram_data_q    <= ram_data_d;
            usb_data_q    <= usb_data_d;
            ram_oe_q      <= ram_oe_d;
            ram_we_n_q    <= ram_we_n_d;
            usb_write_q   <= usb_write_d;
            cpu_hold_q    <= cpu_hold_d;
            usb_dropped_q <= usb_dropped_d;
`ifdef ROM_WRITE_TRAP_EN
            rom_fault_q   <= rom_fault_d;
`endif
        end
    end

    assign ramDataOut = ram_data_q;
    assign ramDataOe  = ram_oe_q;
    assign ramWeN     = ram_we_n_q;
    assign usbDataOut = usb_data_q;
    assign usbWrite   = usb_write_q;
    assign cpuHold    = cpu_hold_q;
    assign usbDropped = usb_dropped_q;
`ifdef ROM_WRITE_TRAP_EN
    assign romWriteFault = rom_fault_q;
`endif

endmodule

// File: tb/tb_data_write_bus.sv
// Self-checking bench for data_write_bus: two instances (default and short-timeout / 3-cycle WE)
// driven by directed then random stimulus, compared every cycle against a transaction-level model.
module tb_data_write_bus;

    localparam int WE_CYC [2] = '{2, 3};
    localparam int TMO    [2] = '{255, 4};

    logic       clk = 1'b0;
    logic       reset, cpuRw, cpuStart, romSelect, ramSelect, usbSelect, usbReady;
    logic [7:0] cpuData;

    logic [7:0] a_ramDataOut, a_usbDataOut, b_ramDataOut, b_usbDataOut;
    logic       a_ramDataOe, a_ramWeN, a_usbWrite, a_cpuHold, a_usbDropped;
    logic       b_ramDataOe, b_ramWeN, b_usbWrite, b_cpuHold, b_usbDropped;
    logic       a_romWriteFault, b_romWriteFault;

    int errors = 0;
    int checks = 0;
    int cnt_hold, cnt_wen_low, cnt_usbw;

    // model: kind 0 idle, 1 RAM write (age = cycle within it), 2 USB waiting (age = cycles waited), 3 USB strobe
    int         kind [2];
    int         age  [2];
    logic [7:0] m_ram [2];
    logic [7:0] m_usb [2];
    logic       m_drop [2];
    logic       m_fault [2];

    always #5 clk = ~clk;

    data_write_bus #(.RAM_WE_CYCLES(2), .USB_TIMEOUT(255)) dut_a (
        .clk(clk), .reset(reset), .cpuData(cpuData), .cpuRw(cpuRw), .cpuStart(cpuStart),
        .romSelect(romSelect), .ramSelect(ramSelect), .usbSelect(usbSelect),
        .ramDataOut(a_ramDataOut), .ramDataOe(a_ramDataOe), .ramWeN(a_ramWeN),
        .usbDataOut(a_usbDataOut), .usbWrite(a_usbWrite), .usbReady(usbReady),
        .cpuHold(a_cpuHold), .usbDropped(a_usbDropped)
`ifdef ROM_WRITE_TRAP_EN
        , .romWriteFault(a_romWriteFault)
`endif
    );

    data_write_bus #(.RAM_WE_CYCLES(3), .USB_TIMEOUT(4)) dut_b (
        .clk(clk), .reset(reset), .cpuData(cpuData), .cpuRw(cpuRw), .cpuStart(cpuStart),
        .romSelect(romSelect), .ramSelect(ramSelect), .usbSelect(usbSelect),
        .ramDataOut(b_ramDataOut), .ramDataOe(b_ramDataOe), .ramWeN(b_ramWeN),
        .usbDataOut(b_usbDataOut), .usbWrite(b_usbWrite), .usbReady(usbReady),
        .cpuHold(b_cpuHold), .usbDropped(b_usbDropped)
`ifdef ROM_WRITE_TRAP_EN
        , .romWriteFault(b_romWriteFault)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int d);
        if (reset) begin
            kind[d] = 0; age[d] = 0; m_ram[d] = 8'h00; m_usb[d] = 8'h00;
            m_drop[d] = 1'b0; m_fault[d] = 1'b0;
        end else begin
            case (kind[d])
                0: if (cpuStart && !cpuRw) begin
                    if (romSelect) m_fault[d] = 1'b1;
                    else if (ramSelect) begin kind[d] = 1; age[d] = 1; m_ram[d] = cpuData; end
                    else if (usbSelect) begin kind[d] = 2; age[d] = 0; m_usb[d] = cpuData; end
                end
                1: begin
                    age[d]++;
                    if (age[d] > WE_CYC[d] + 2) kind[d] = 0;
                end
                2: if (usbReady) kind[d] = 3;
                   else begin
                       age[d]++;
                       if (TMO[d] != 0 && age[d] == TMO[d]) begin kind[d] = 0; m_drop[d] = 1'b1; end
                   end
                default: kind[d] = 0;
            endcase
        end
    endtask

    task automatic compare(input int d, input string p, input logic [7:0] rdo, input logic oe,
                           input logic wen, input logic [7:0] udo, input logic uw, input logic hold,
                           input logic drop, input logic fault);
        logic exp_wen;
        exp_wen = !(kind[d] == 1 && age[d] >= 2 && age[d] <= WE_CYC[d] + 1);
        check({p, ".ramDataOut"}, 32'(rdo), 32'(m_ram[d]));
        check({p, ".ramDataOe"}, 32'(oe), 32'(kind[d] == 1));
        check({p, ".ramWeN"}, 32'(wen), 32'(exp_wen));
        check({p, ".usbDataOut"}, 32'(udo), 32'(m_usb[d]));
        check({p, ".usbWrite"}, 32'(uw), 32'(kind[d] == 3));
        check({p, ".cpuHold"}, 32'(hold), 32'(kind[d] != 0));
        check({p, ".usbDropped"}, 32'(drop), 32'(m_drop[d]));
`ifdef ROM_WRITE_TRAP_EN
        check({p, ".romWriteFault"}, 32'(fault), 32'(m_fault[d]));
`else
        if (fault === 1'b1) check({p, ".romWriteFault_unused"}, 32'(fault), 32'd0);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        compare(0, "a", a_ramDataOut, a_ramDataOe, a_ramWeN, a_usbDataOut, a_usbWrite, a_cpuHold,
                a_usbDropped, a_romWriteFault);
        compare(1, "b", b_ramDataOut, b_ramDataOe, b_ramWeN, b_usbDataOut, b_usbWrite, b_cpuHold,
                b_usbDropped, b_romWriteFault);
        if (a_cpuHold) cnt_hold++;
        if (!a_ramWeN) cnt_wen_low++;
        if (a_usbWrite) cnt_usbw++;
    endtask

    task automatic quiet();
        reset = 1'b0; cpuStart = 1'b0; cpuRw = 1'b0; romSelect = 1'b0; ramSelect = 1'b0;
        usbSelect = 1'b0; cpuData = 8'h00; usbReady = 1'b0;
    endtask

    task automatic clear_counts();
        cnt_hold = 0; cnt_wen_low = 0; cnt_usbw = 0;
    endtask

    task automatic write(input logic [7:0] data, input logic rom, input logic ram, input logic usb);
        cpuStart = 1'b1; cpuRw = 1'b0; cpuData = data;
        romSelect = rom; ramSelect = ram; usbSelect = usb;
        tick();
        cpuStart = 1'b0; romSelect = 1'b0; ramSelect = 1'b0; usbSelect = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        quiet();
        reset = 1'b1;
        clear_counts();
        tick(); tick();
        check("reset.ramWeN", 32'(a_ramWeN), 32'd1);
        check("reset.cpuHold", 32'(a_cpuHold), 32'd0);
        reset = 1'b0;
        tick();

        // RAM write 0xA5: setup, 2 WE-low cycles, hold, then idle
        clear_counts();
        write(8'hA5, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        check("ram.hold_cycles", 32'(cnt_hold), 32'd4);
        check("ram.we_low_cycles", 32'(cnt_wen_low), 32'd2);
        check("ram.data", 32'(a_ramDataOut), 32'hA5);

        // CPU read strobe is ignored
        cpuStart = 1'b1; cpuRw = 1'b1; ramSelect = 1'b1; cpuData = 8'h99;
        tick();
        quiet();
        tick();

        // second start during RAM_WE must not disturb a 0x12 write
        write(8'h12, 1'b0, 1'b1, 1'b0);
        tick();
        cpuStart = 1'b1; cpuRw = 1'b0; ramSelect = 1'b1; cpuData = 8'hFF;
        tick();
        quiet();
        for (int i = 0; i < 5; i++) tick();
        check("ram.ignore_second", 32'(a_ramDataOut), 32'h12);

        // USB write 0x41 with ready low 10 cycles, then high
        clear_counts();
        write(8'h41, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        check("usb.b_dropped", 32'(b_usbDropped), 32'd1);
        usbReady = 1'b1;
        tick();
        usbReady = 1'b0;
        check("usb.pulse_now", 32'(a_usbWrite), 32'd1);
        check("usb.data", 32'(a_usbDataOut), 32'h41);
        for (int i = 0; i < 3; i++) tick();
        check("usb.pulse_count", 32'(cnt_usbw), 32'd1);
        check("usb.hold_released", 32'(a_cpuHold), 32'd0);

        // all selects: ROM wins, nothing happens on RAM or USB
        clear_counts();
        write(8'h3C, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        check("prio.no_activity", 32'(cnt_hold + cnt_wen_low + cnt_usbw), 32'd0);

        // reset in the middle of RAM_WE
        write(8'h77, 1'b0, 1'b1, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        check("rst_we.ramWeN", 32'(a_ramWeN), 32'd1);
        check("rst_we.ramDataOe", 32'(a_ramDataOe), 32'd0);
        check("rst_we.cpuHold", 32'(a_cpuHold), 32'd0);
        check("rst_we.ramDataOut", 32'(a_ramDataOut), 32'h00);

        // cpuStart coincident with reset is ignored
        cpuStart = 1'b1; cpuRw = 1'b0; ramSelect = 1'b1; cpuData = 8'h5A;
        tick();
        quiet();
        tick();
        check("rst_start.cpuHold", 32'(a_cpuHold), 32'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 99) == 0);
            cpuStart  = ($urandom_range(0, 3) == 0);
            cpuRw     = ($urandom_range(0, 3) == 0);
            romSelect = ($urandom_range(0, 5) == 0);
            ramSelect = $urandom_range(0, 1) == 1;
            usbSelect = $urandom_range(0, 1) == 1;
            cpuData   = 8'($urandom);
            usbReady  = ($urandom_range(0, 4) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
